// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   if_state_e  : fetch FSM states
//   PC_INC      : sequential fetch stride in bytes
//   IF_RESET_PC : default fetch address after reset
//   IF_NOP_INS  : default instruction word driven when nothing valid is held
//   align_pc()  : clears the two byte-offset bits of an address
package if_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,  // request pending at pc
    S_WAIT  = 2'd1,  // one request outstanding, waiting for its response
    S_OUT   = 2'd2,  // instruction held on IF_pc/IF_ins for the decode stage
    S_DRAIN = 2'd3   // stale request outstanding, its response will be dropped
  } if_state_e;

  localparam logic [31:0] PC_INC      = 32'd4;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IF_NOP_INS  = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program-counter register of the fetch stage.
// Priority: rst > redirect > inc. The increment wraps modulo 2^32.
// Build option IF_MISALIGN_CHK_EN: redirect targets are word-aligned on load.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   redirect     : load redirect_pc
//   redirect_pc  : redirect target
//   inc          : advance pc by PC_INC
//   pc           : current fetch address
module if_pc_reg
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        inc,
  output logic [31:0] pc
);

  logic [31:0] redirect_tgt;

`ifdef IF_MISALIGN_CHK_EN
  assign redirect_tgt = align_pc(redirect_pc);
`else
  // Low bits pass straight through to the fetch address.
  assign redirect_tgt = redirect_pc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_tgt;
    end else if (inc) begin
      pc <= pc + PC_INC;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the pc, fetches from instruction memory and
// presents each instruction with its pc+4 to the IF/ID register.
//
// Handshakes:
//   imem request is accepted in a cycle where imem_req && imem_ready; at most
//   one request is outstanding; its response arrives as a one-cycle
//   imem_rvalid with imem_rdata at least one cycle later.
//   The decode side consumes IF_pc/IF_ins in a cycle where IF_valid && !stall;
//   while stalled every output is held.
//
// Build option IF_MISALIGN_CHK_EN: adds the misalign output, a one-cycle pulse
// after a redirect whose target is not word aligned (the target is aligned).
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   stall                  : decode side not accepting
//   redirect, redirect_pc  : branch/jump redirect and its target
//   imem_req, imem_addr    : fetch request and address (= pc), combinational
//   imem_ready             : memory accepts the request
//   imem_rvalid, imem_rdata: memory response
//   IF_pc, IF_ins, IF_valid: registered fetch output
//   misalign               : misaligned redirect pulse (option only)
//   dbg_state              : current FSM state for observation
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC,
  parameter logic [31:0] NOP_INS  = IF_NOP_INS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_pc,
  output logic [31:0] IF_ins,
  output logic        IF_valid,
`ifdef IF_MISALIGN_CHK_EN
  output logic        misalign,
`endif
  output logic [1:0]  dbg_state
);

  if_state_e   state;
  if_state_e   state_nxt;
  logic [31:0] pc;
  logic        accept;
  logic        pc_inc;
  logic        load_out;
  logic        clear_out;

  if_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inc         (pc_inc),
    .pc          (pc)
  );

  assign imem_req  = (state == S_REQ) || ((state == S_OUT) && !stall);
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_inc    = 1'b0;
    load_out  = 1'b0;
    clear_out = 1'b0;
    if (redirect) begin
      clear_out = 1'b1;
      // A request still in flight must have its response swallowed before
      // fetching from the new target; a response landing this very cycle
      // is simply ignored.
      if (((state == S_WAIT) || (state == S_DRAIN) || accept) && !imem_rvalid) begin
        state_nxt = S_DRAIN;
      end else begin
        state_nxt = S_REQ;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (accept) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            load_out  = 1'b1;
            pc_inc    = 1'b1;
            state_nxt = S_OUT;
          end
        end
        S_OUT: begin
          if (!stall) begin
            clear_out = 1'b1;
            state_nxt = accept ? S_WAIT : S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) state_nxt = S_REQ;
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

  // pc still holds the fetched address when the response lands, so the
  // presented pc+4 is taken from it before it advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      IF_pc    <= 32'h0000_0000;
      IF_ins   <= NOP_INS;
      IF_valid <= 1'b0;
    end else if (load_out) begin
      IF_pc    <= pc + PC_INC;
      IF_ins   <= imem_rdata;
      IF_valid <= 1'b1;
    end else if (clear_out) begin
      IF_ins   <= NOP_INS;
      IF_valid <= 1'b0;
    end
  end

`ifdef IF_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
    end else begin
      misalign <= redirect && (redirect_pc[1:0] != 2'b00);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized traffic, with a
// memory model and a scoreboard that tracks the expected instruction stream.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_pc;
  logic [31:0] IF_ins;
  logic        IF_valid;
`ifdef IF_MISALIGN_CHK_EN
  logic        misalign;
`endif
  logic [1:0]  dbg_state;

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .IF_pc       (IF_pc),
    .IF_ins      (IF_ins),
    .IF_valid    (IF_valid),
`ifdef IF_MISALIGN_CHK_EN
    .misalign    (misalign),
`endif
    .dbg_state   (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_present = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- memory model ----------------
  logic        zero_wait;
  int          lat_fix;      // 0 selects a random latency
  logic        acc_seen;     // written by the monitor at negedge
  logic [31:0] acc_addr;
  logic        m_busy;
  logic [31:0] m_addr;
  int          m_left;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] model_tgt(input logic [31:0] a);
`ifdef IF_MISALIGN_CHK_EN
    return {a[31:2], 2'b00};
`else
    return a;
`endif
  endfunction

  always @(posedge clk) begin
    #1;
    imem_ready = zero_wait ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (rst) begin
      m_busy      = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end else begin
      imem_rvalid = 1'b0;
      if (acc_seen) begin
        m_busy = 1'b1;
        m_addr = acc_addr;
        m_left = ((lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4))) - 1;
      end else if (m_busy) begin
        m_left = m_left - 1;
      end
      if (m_busy && (m_left == 0)) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(m_addr);
        m_busy      = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] exp_q[$];     // addresses whose instructions must be presented, in order
  logic [31:0] exp_fetch;    // next address the stage must request
  logic        prev_redir;
  logic [31:0] prev_tgt;
  logic [31:0] e_pc;
  logic [31:0] e_ins;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_fetch  = 32'h0;
      acc_seen   = 1'b0;
      prev_redir = 1'b0;
      prev_tgt   = 32'h0;
    end else begin
      if (IF_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: IF_pc=%h IF_ins=%h presented, required no instruction", IF_pc, IF_ins);
        end else begin
          e_pc  = exp_q[0] + 32'd4;
          e_ins = mem_word(exp_q[0]);
          if ((IF_pc !== e_pc) || (IF_ins !== e_ins)) begin
            n_err++;
            $display("FAIL sb_stream: got pc=%h ins=%h, required pc=%h ins=%h", IF_pc, IF_ins, e_pc, e_ins);
          end
        end
        if (stall) begin
          n_vec++;
          if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL sb_stall_req: imem_req=%b while stalled output held, required 0", imem_req);
          end
        end
      end
      if (prev_redir) begin
        n_vec++;
        if (IF_valid !== 1'b0) begin
          n_err++;
          $display("FAIL sb_redirect_kill: IF_valid=%b after redirect, required 0", IF_valid);
        end
      end
`ifdef IF_MISALIGN_CHK_EN
      n_vec++;
      if (misalign !== (prev_redir && (prev_tgt[1:0] != 2'b00))) begin
        n_err++;
        $display("FAIL sb_misalign: misalign=%b, required %b", misalign, prev_redir && (prev_tgt[1:0] != 2'b00));
      end
`endif
      acc_seen = imem_req && imem_ready;
      if (acc_seen) begin
        n_vec++;
        if (m_busy || imem_rvalid) begin
          n_err++;
          $display("FAIL sb_outstanding: request accepted with %0d already outstanding, required 0", 1);
        end
        n_vec++;
        if (imem_addr !== exp_fetch) begin
          n_err++;
          $display("FAIL sb_fetch_addr: imem_addr=%h, required %h", imem_addr, exp_fetch);
        end
        acc_addr = imem_addr;
        exp_q.push_back(exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (IF_valid && !stall && !redirect && (exp_q.size() != 0)) begin
        void'(exp_q.pop_front());
        n_present++;
      end
      if (redirect) begin
        exp_q.delete();
        exp_fetch = model_tgt(redirect_pc);
      end
      prev_redir = redirect;
      prev_tgt   = redirect_pc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_redirect(input logic [31:0] tgt);
    tick();
    redirect    = 1'b1;
    redirect_pc = tgt;
    tick();
    redirect    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ((IF_valid !== 1'b0) || (IF_pc !== 32'h0) || (IF_ins !== 32'h0)) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b pc=%h ins=%h, required 0/0/0", IF_valid, IF_pc, IF_ins);
    end
`ifdef IF_MISALIGN_CHK_EN
    n_vec++;
    if (misalign !== 1'b0) begin
      n_err++;
      $display("FAIL reset_misalign: misalign=%b, required 0", misalign);
    end
`endif
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ((imem_req !== 1'b1) || (imem_addr !== 32'h0)) begin
      n_err++;
      $display("FAIL first_req: req=%b addr=%h, required 1/00000000", imem_req, imem_addr);
    end
    @(negedge clk);
    n_vec++;
    if (IF_valid !== 1'b0) begin
      n_err++;
      $display("FAIL first_wait: IF_valid=%b, required 0", IF_valid);
    end
    @(negedge clk);
    n_vec++;
    if ((IF_valid !== 1'b1) || (IF_pc !== 32'h4) || (IF_ins !== 32'h2008_0005)) begin
      n_err++;
      $display("FAIL first_out: valid=%b pc=%h ins=%h, required 1/00000004/20080005", IF_valid, IF_pc, IF_ins);
    end
  endtask

  task automatic test_stall();
    logic got = 1'b0;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (IF_valid) begin
        got = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL stall_timeout: no instruction within 20 cycles, required one");
    end
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      n_vec++;
      if ((IF_valid !== 1'b1) || (IF_pc !== 32'h8) || (IF_ins !== mem_word(32'h4)) || (imem_req !== 1'b0)) begin
        n_err++;
        $display("FAIL stall_hold: valid=%b pc=%h ins=%h req=%b, required 1/00000008/%h/0",
                 IF_valid, IF_pc, IF_ins, imem_req, mem_word(32'h4));
      end
    end
    tick();
    stall = 1'b0;
    @(negedge clk);
    n_vec++;
    if ((imem_req !== 1'b1) || (imem_addr !== 32'h8)) begin
      n_err++;
      $display("FAIL stall_release: req=%b addr=%h, required 1/00000008", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    logic got = 1'b0;
    lat_fix = 3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req && imem_ready) begin
        got = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL redir_wait_timeout: no accepted request within 20 cycles, required one");
    end
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if ((IF_valid !== 1'b0) || (imem_req !== 1'b0)) begin
        n_err++;
        $display("FAIL redir_wait_drain: cycle %0d valid=%b req=%b, required 0/0", i, IF_valid, imem_req);
      end
    end
    @(negedge clk);
    n_vec++;
    if ((IF_valid !== 1'b0) || (imem_req !== 1'b1) || (imem_addr !== 32'h40)) begin
      n_err++;
      $display("FAIL redir_wait_req: valid=%b req=%b addr=%h, required 0/1/00000040", IF_valid, imem_req, imem_addr);
    end
    lat_fix = 1;
  endtask

  task automatic test_redirect_accept();
    logic got = 1'b0;
    lat_fix = 2;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (IF_valid) begin
        got = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL redir_acc_timeout: no instruction within 20 cycles, required one");
    end
    tick();
    stall       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    @(negedge clk);
    n_vec++;
    if (imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL redir_acc_req: req=%b in redirect cycle, required 1", imem_req);
    end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    n_vec++;
    if ((imem_req !== 1'b0) || (IF_valid !== 1'b0)) begin
      n_err++;
      $display("FAIL redir_acc_drain: req=%b valid=%b, required 0/0", imem_req, IF_valid);
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (IF_valid) begin
        got = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!got || (IF_pc !== 32'h104) || (IF_ins !== mem_word(32'h100))) begin
      n_err++;
      $display("FAIL redir_acc_out: seen=%b pc=%h ins=%h, required 1/00000104/%h", got, IF_pc, IF_ins, mem_word(32'h100));
    end
    lat_fix = 1;
  endtask

  task automatic test_wrap();
    logic got = 1'b0;
    pulse_redirect(32'hFFFF_FFFC);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (IF_valid) begin
        got = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!got || (IF_pc !== 32'h0) || (IF_ins !== mem_word(32'hFFFF_FFFC))) begin
      n_err++;
      $display("FAIL wrap_out: seen=%b pc=%h ins=%h, required 1/00000000/%h", got, IF_pc, IF_ins, mem_word(32'hFFFF_FFFC));
    end
    n_vec++;
    if ((imem_req !== 1'b1) || (imem_addr !== 32'h0)) begin
      n_err++;
      $display("FAIL wrap_next_addr: req=%b addr=%h, required 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_misalign();
    logic        got = 1'b0;
    logic [31:0] want;
`ifdef IF_MISALIGN_CHK_EN
    want = 32'h0000_0040;
`else
    want = 32'h0000_0042;
`endif
    pulse_redirect(32'h0000_0042);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
`ifdef IF_MISALIGN_CHK_EN
      if (i < 2) begin
        n_vec++;
        if (misalign !== (i == 0)) begin
          n_err++;
          $display("FAIL misalign_pulse: cycle %0d misalign=%b, required %b", i, misalign, (i == 0));
        end
      end
`endif
      if (imem_req && !got) begin
        got = 1'b1;
        n_vec++;
        if (imem_addr !== want) begin
          n_err++;
          $display("FAIL misalign_addr: imem_addr=%h, required %h", imem_addr, want);
        end
      end
      if (got && (i >= 1)) break;
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL misalign_timeout: no request within 20 cycles, required one");
    end
  endtask

  task automatic test_random();
    int start = n_present;
    zero_wait = 1'b0;
    lat_fix   = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      stall    = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 7) == 0) redirect_pc = $urandom;
      else if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00};
      else redirect_pc = {$urandom_range(0, 65535), 2'b00};
    end
    tick();
    stall    = 1'b0;
    redirect = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    n_vec++;
    if ((n_present - start) < 100) begin
      n_err++;
      $display("FAIL random_progress: %0d instructions consumed, required at least 100", n_present - start);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    zero_wait   = 1'b1;
    lat_fix     = 1;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    acc_seen    = 1'b0;
    acc_addr    = 32'h0;
    m_busy      = 1'b0;
    m_addr      = 32'h0;
    m_left      = 0;
    test_reset();
    test_stall();
    test_redirect_wait();
    test_redirect_accept();
    test_wrap();
    test_misalign();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
